// File: rtl/comparator_sar_search.sv
// Successive-approximation search initiator for an N-bit magnitude comparator.
// Drives trial values MSB first, samples the comparator flags CMP_LATENCY cycles
// after each trial update, and reports the value held on the comparator's A input.
module comparator_sar_search #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CMP_LATENCY = 1
) (
    input  logic                  Clock_In,
    input  logic                  Reset_n_In,
    input  logic                  Start_In,
    output logic                  Cmp_Enable_Out,
    output logic [DATA_WIDTH-1:0] Cmp_Data_B_Out,
    input  logic                  A_gt_B_In,
    input  logic                  A_eq_B_In,
    input  logic                  A_lt_B_In,
    output logic                  Busy_Out,
    output logic                  Done_Out,
    output logic [DATA_WIDTH-1:0] Result_Out,
    output logic                  Error_Out
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned CNT_W = $clog2(CMP_LATENCY + 1);

    localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(CMP_LATENCY - 1);

    typedef enum logic {
        IDLE,
        COMPARE
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] acc, acc_nxt;
    logic [IDX_W-1:0]      bit_idx, bit_idx_nxt;
    logic [CNT_W-1:0]      wait_cnt, wait_cnt_nxt;
    logic                  enable_nxt;
    logic [DATA_WIDTH-1:0] data_b_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;
    logic [DATA_WIDTH-1:0] result_nxt;
    logic                  error_nxt;

    // Helper terms for the sample edge
    logic [DATA_WIDTH-1:0] trial;
    logic [DATA_WIDTH-1:0] acc_step;
    logic [IDX_W-1:0]      bit_dec;
    logic                  step;
    logic                  finish;

    // State and output registers
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state          <= IDLE;
            acc            <= '0;
            bit_idx        <= '0;
            wait_cnt       <= '0;
            Cmp_Enable_Out <= 1'b0;
            Cmp_Data_B_Out <= '0;
            Busy_Out       <= 1'b0;
            Done_Out       <= 1'b0;
            Result_Out     <= '0;
            Error_Out      <= 1'b0;
        end else begin
            state          <= state_nxt;
            acc            <= acc_nxt;
            bit_idx        <= bit_idx_nxt;
            wait_cnt       <= wait_cnt_nxt;
            Cmp_Enable_Out <= enable_nxt;
            Cmp_Data_B_Out <= data_b_nxt;
            Busy_Out       <= busy_nxt;
            Done_Out       <= done_nxt;
            Result_Out     <= result_nxt;
            Error_Out      <= error_nxt;
        end
    end

    // Next-state and output logic: one trial per CMP_LATENCY cycles, early exit on eq
    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        bit_idx_nxt  = bit_idx;
        wait_cnt_nxt = wait_cnt;
        enable_nxt   = Cmp_Enable_Out;
        data_b_nxt   = Cmp_Data_B_Out;
        busy_nxt     = Busy_Out;
        done_nxt     = 1'b0;
        result_nxt   = Result_Out;
        error_nxt    = Error_Out;

        trial    = acc | (DATA_WIDTH'(1) << bit_idx);
        acc_step = acc;
        bit_dec  = IDX_W'(bit_idx - 1'b1);
        step     = 1'b0;
        finish   = 1'b0;

        case (state)
            IDLE: begin
                if (Start_In) begin
                    state_nxt    = COMPARE;
                    acc_nxt      = '0;
                    bit_idx_nxt  = TOP_IDX;
                    wait_cnt_nxt = '0;
                    data_b_nxt   = DATA_WIDTH'(1) << TOP_IDX;
                    enable_nxt   = 1'b1;
                    busy_nxt     = 1'b1;
                    error_nxt    = 1'b0;
                end
            end

            COMPARE: begin
                if (wait_cnt == SAMPLE_AT) begin
                    // case compares with ===, so X/Z flag patterns fall to default
                    case ({A_gt_B_In, A_eq_B_In, A_lt_B_In})
                        3'b010: begin
                            finish     = 1'b1;
                            result_nxt = trial;
                        end
                        3'b100: begin
                            step     = 1'b1;
                            acc_step = trial;
                        end
                        3'b001: begin
                            step     = 1'b1;
                        end
                        default: begin
                            finish    = 1'b1;
                            error_nxt = 1'b1;
                        end
                    endcase

                    if (step) begin
                        acc_nxt = acc_step;
                        if (bit_idx == '0) begin
                            finish     = 1'b1;
                            result_nxt = acc_step;
                        end else begin
                            bit_idx_nxt  = bit_dec;
                            data_b_nxt   = acc_step | (DATA_WIDTH'(1) << bit_dec);
                            wait_cnt_nxt = '0;
                        end
                    end
                end else begin
                    wait_cnt_nxt = CNT_W'(wait_cnt + 1'b1);
                end

                if (finish) begin
                    state_nxt  = IDLE;
                    done_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
                    enable_nxt = 1'b0;
                    data_b_nxt = '0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_comparator_sar_search.sv
// Bench for comparator_sar_search: three instances (latency 1, 2, 3), each paired
// with a behavioural 8-bit comparator, checked against a binary-search reference.
module tb_comparator_sar_search;

    localparam int unsigned W = 8;
    localparam int unsigned N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]        start;
    logic [N-1:0][W-1:0] a_val;
    logic [N-1:0]        force_on;
    logic [N-1:0][2:0]   force_val;

    logic [N-1:0]        en;
    logic [N-1:0][W-1:0] data_b;
    logic [N-1:0]        gt;
    logic [N-1:0]        eq;
    logic [N-1:0]        lt;
    logic [N-1:0]        busy;
    logic [N-1:0]        done;
    logic [N-1:0][W-1:0] result;
    logic [N-1:0]        error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Comparator partner per instance (flags low when disabled); force_on overrides flags
    for (genvar i = 0; i < N; i++) begin : g_dut
        assign gt[i] = force_on[i] ? force_val[i][2] : (en[i] && (a_val[i] >  data_b[i]));
        assign eq[i] = force_on[i] ? force_val[i][1] : (en[i] && (a_val[i] == data_b[i]));
        assign lt[i] = force_on[i] ? force_val[i][0] : (en[i] && (a_val[i] <  data_b[i]));

        comparator_sar_search #(
            .DATA_WIDTH (W),
            .CMP_LATENCY(i + 1)
        ) u_dut (
            .Clock_In      (clk),
            .Reset_n_In    (rst_n),
            .Start_In      (start[i]),
            .Cmp_Enable_Out(en[i]),
            .Cmp_Data_B_Out(data_b[i]),
            .A_gt_B_In     (gt[i]),
            .A_eq_B_In     (eq[i]),
            .A_lt_B_In     (lt[i]),
            .Busy_Out      (busy[i]),
            .Done_Out      (done[i]),
            .Result_Out    (result[i]),
            .Error_Out     (error[i])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Trial k of a binary search for a: top k bits of a, then a one below them
    function automatic int ref_trial(input int a, input int k);
        int mask;
        if (k >= 8) return 0;
        mask = (32'hFF << (8 - k)) & 32'hFF;
        return (a & mask) | (1 << (7 - k));
    endfunction

    // Number of trials: ends when the trial equals a (at a's lowest set bit), else 8
    function automatic int ref_trials(input int a);
        int n;
        if (a == 0) return 8;
        n = 0;
        while (((a >> n) & 1) == 0) n++;
        return 8 - n;
    endfunction

    // One complete search on instance d; returns at the Done sample point
    task automatic run_search(input int d, input int a, input bit hold);
        int lat;
        int j;
        int prev_res;
        lat = ref_trials(a) * (d + 1);
        a_val[d] = W'(a);
        @(negedge clk);
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start[d] = 1'b0;
        check("err_clear_on_start", 32'(error[d]), 0);
        j = 0;
        while (!done[d] && j < 200) begin
            check("busy", 32'(busy[d]), 1);
            check("enable", 32'(en[d]), 1);
            if (j / (d + 1) < 8)
                check("trial", 32'(data_b[d]), 32'(ref_trial(a, j / (d + 1))));
            @(posedge clk);
            #1;
            j++;
        end
        start[d] = 1'b0;
        prev_res = int'(result[d]);
        check("latency", 32'(j), 32'(lat));
        check("result", 32'(prev_res), 32'(a));
        check("done_busy", 32'(busy[d]), 0);
        check("done_enable", 32'(en[d]), 0);
        check("done_data_b", 32'(data_b[d]), 0);
        check("done_error", 32'(error[d]), 0);
    endtask

    // Search with forced flags on the first sample (latency-1 instance)
    task automatic run_forced(input logic [2:0] flags, input int prev_res);
        force_on[0]  = 1'b1;
        force_val[0] = flags;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        check("forced_busy", 32'(busy[0]), 1);
        @(posedge clk);
        #1;
        check("forced_done", 32'(done[0]), 1);
        check("forced_error", 32'(error[0]), 1);
        check("forced_result", 32'(result[0]), 32'(prev_res));
        check("forced_busy_end", 32'(busy[0]), 0);
        @(posedge clk);
        #1;
        check("forced_done_pulse", 32'(done[0]), 0);
        check("forced_error_held", 32'(error[0]), 1);
        force_on[0] = 1'b0;
    endtask

    initial begin
        int a;
        bit saw_done;
        start     = '0;
        a_val     = '0;
        force_on  = '0;
        force_val = '0;

        #12;
        for (int i = 0; i < int'(N); i++) begin
            check("rst_enable", 32'(en[i]), 0);
            check("rst_data_b", 32'(data_b[i]), 0);
            check("rst_busy", 32'(busy[i]), 0);
            check("rst_done", 32'(done[i]), 0);
            check("rst_result", 32'(result[i]), 0);
            check("rst_error", 32'(error[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_search(0, 'hA5, 1'b0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done[0]), 0);
        check("result_held", 32'(result[0]), 'hA5);
        run_search(0, 'h80, 1'b0);
        run_search(0, 'h00, 1'b0);
        run_search(2, 'hFF, 1'b0);
        run_search(0, 'h3C, 1'b1);
        @(posedge clk);
        #1;
        check("no_restart_after_hold", 32'(busy[0]), 0);

        // Bad flag patterns
        run_forced(3'b000, 'h3C);
        run_forced(3'b101, 'h3C);
        run_search(0, 'h5A, 1'b0);

        // Reset in the middle of a search
        a_val[0] = 8'hC3;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_enable", 32'(en[0]), 0);
        check("mid_rst_data_b", 32'(data_b[0]), 0);
        check("mid_rst_busy", 32'(busy[0]), 0);
        check("mid_rst_done", 32'(done[0]), 0);
        check("mid_rst_result", 32'(result[0]), 0);
        check("mid_rst_error", 32'(error[0]), 0);
        saw_done = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done[0]) saw_done = 1'b1;
        end
        check("mid_rst_no_done", 32'(saw_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_search(0, 'hC3, 1'b0);

        // Randomized back-to-back searches for latency 1 and 2
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 200; n++) begin
                a = int'($urandom_range(0, 255));
                run_search(d, a, ($urandom_range(0, 3) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
